// File: rtl/adrv9009_rfir_loader.sv
// rtl/adrv9009_rfir_loader.sv - receive FIR quiesce / coefficient load / atomic commit controller
// Optional checksum verification of the coefficient stream: define RFIR_LOADER_CHECKSUM_EN.
module adrv9009_rfir_loader #(
   parameter int FLUSH_CYCLES = 8,
   parameter int ADDR_W       = 7,
   parameter int COEFF_W      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req,
   input  logic [1:0]                req_mode,
   input  logic [1:0]                req_gain,
   input  logic [1:0]                req_deci,
   input  logic                      req_en,
`ifdef RFIR_LOADER_CHECKSUM_EN
   input  logic [COEFF_W-1:0]        chk,
`endif
   input  logic                      c_valid,
   input  logic signed [COEFF_W-1:0] c_data,
   output logic                      c_ready,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic                      en_rfir,
   output logic [1:0]                mode_rfir,
   output logic [1:0]                gain_rfir,
   output logic [1:0]                deci_rfir,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         addr_in,
   output logic signed [COEFF_W-1:0] coeff_in
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_QUIESCE = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_COMMIT  = 3'd3;
   localparam logic [2:0] S_ERROR   = 3'd4;

   logic [2:0]        state;
   logic [CNT_W-1:0]  flush_cnt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] last_idx;
   logic [1:0]        pend_mode;
   logic [1:0]        pend_gain;
   logic [1:0]        pend_deci;
   logic              pend_en;
   logic              shadow_en;
   logic              beat;
   logic              sum_ok;

   assign c_ready = (state == S_LOAD);
   assign busy    = (state != S_IDLE);
   assign beat    = c_valid && c_ready;

   always_comb begin
      last_idx = ADDR_W'(71);
      case (pend_mode)
         2'd0:    last_idx = ADDR_W'(23);
         2'd1:    last_idx = ADDR_W'(47);
         default: last_idx = ADDR_W'(71);
      endcase
   end

`ifdef RFIR_LOADER_CHECKSUM_EN
   logic [COEFF_W-1:0] pend_chk;
   logic [COEFF_W-1:0] sum;

   assign sum_ok = (sum == pend_chk);

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_chk <= '0;
         sum      <= '0;
      end else if (state == S_IDLE && req && req_mode != 2'd3) begin
         pend_chk <= chk;
         sum      <= '0;
      end else if (beat) begin
         sum <= sum + c_data;
      end
   end
`else
   assign sum_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         flush_cnt <= '0;
         idx       <= '0;
         pend_mode <= 2'd0;
         pend_gain <= 2'd0;
         pend_deci <= 2'd0;
         pend_en   <= 1'b0;
         shadow_en <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         en_rfir   <= 1'b0;
         mode_rfir <= 2'd0;
         gain_rfir <= 2'd0;
         deci_rfir <= 2'd0;
         wr_en     <= 1'b0;
         addr_in   <= '0;
         coeff_in  <= '0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  if (req_mode == 2'd3) begin
                     err <= 1'b1;
                  end else begin
                     pend_mode <= req_mode;
                     pend_gain <= req_gain;
                     pend_deci <= req_deci;
                     pend_en   <= req_en;
                     err       <= 1'b0;
                     en_rfir   <= 1'b0;
                     flush_cnt <= '0;
                     state     <= S_QUIESCE;
                  end
               end
            end
            S_QUIESCE: begin
               if (flush_cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
                  idx   <= '0;
                  state <= S_LOAD;
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
               end
            end
            S_LOAD: begin
               if (beat) begin
                  wr_en    <= 1'b1;
                  addr_in  <= idx;
                  coeff_in <= c_data;
                  idx      <= idx + 1'b1;
                  if (idx == last_idx)
                     state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               if (sum_ok) begin
                  mode_rfir <= pend_mode;
                  gain_rfir <= pend_gain;
                  deci_rfir <= pend_deci;
                  en_rfir   <= pend_en;
                  shadow_en <= pend_en;
                  done      <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  // Mode/gain/deci were never touched; only the enable needs restoring.
                  err     <= 1'b1;
                  en_rfir <= shadow_en;
                  state   <= S_ERROR;
               end
            end
            S_ERROR: begin
               err     <= 1'b1;
               en_rfir <= shadow_en;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adrv9009_rfir_loader.sv
// tb/tb_adrv9009_rfir_loader.sv - self-checking bench for adrv9009_rfir_loader
module tb_adrv9009_rfir_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic [1:0]  req_mode = 2'd0;
   logic [1:0]  req_gain = 2'd0;
   logic [1:0]  req_deci = 2'd0;
   logic        req_en = 1'b0;
`ifdef RFIR_LOADER_CHECKSUM_EN
   logic [15:0] chk = 16'd0;
`endif
   logic        c_valid = 1'b0;
   logic [15:0] c_data = 16'd0;
   logic        c_ready, busy, done, err, en_rfir, wr_en;
   logic [1:0]  mode_rfir, gain_rfir, deci_rfir;
   logic [6:0]  addr_in;
   logic [15:0] coeff_in;

   int n_cmp = 0;
   int n_fail = 0;
   int exp_idx = 0;
   int wr_cnt = 0;
   int done_cnt = 0;

   typedef struct {
      int addr;
      int data;
   } wr_t;
   wr_t q[$];

   typedef struct {
      logic [1:0] mode, gain, deci;
      logic       en;
      bit         gap;
      int         base;
      int         exp_wr;
      int         exp_done;
      logic       exp_err;
      logic [1:0] exp_mode, exp_gain, exp_deci;
      logic       exp_en;
   } vec_t;
   vec_t vecs[4];

   always #5 clk = ~clk;

   adrv9009_rfir_loader #(.FLUSH_CYCLES(8), .ADDR_W(7), .COEFF_W(16)) dut (
      .clk(clk), .reset(reset), .req(req), .req_mode(req_mode), .req_gain(req_gain),
      .req_deci(req_deci), .req_en(req_en),
`ifdef RFIR_LOADER_CHECKSUM_EN
      .chk(chk),
`endif
      .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready), .busy(busy), .done(done),
      .err(err), .en_rfir(en_rfir), .mode_rfir(mode_rfir), .gain_rfir(gain_rfir),
      .deci_rfir(deci_rfir), .wr_en(wr_en), .addr_in(addr_in), .coeff_in(coeff_in)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: a beat seen accepted at one falling edge must show up as a write at the next.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         wr_t e;
         e = q.pop_front();
         check("wr_en_latency", int'(wr_en), 1);
         check("wr_addr", int'(addr_in), e.addr);
         check("wr_data", int'(coeff_in), e.data);
      end else if (wr_en) begin
         check("unexpected_write", int'(wr_en), 0);
      end
      if (wr_en) wr_cnt++;
      if (done) done_cnt++;
      if (c_valid && c_ready) begin
         q.push_back('{exp_idx, int'(c_data)});
         exp_idx++;
      end
   end

   task automatic check_cfg(input string tag, input int m, input int g, input int d, input int e);
      check({tag, "_mode"}, int'(mode_rfir), m);
      check({tag, "_gain"}, int'(gain_rfir), g);
      check({tag, "_deci"}, int'(deci_rfir), d);
      check({tag, "_en"}, int'(en_rfir), e);
   endtask

   task automatic do_load(input logic [1:0] m, input logic [1:0] g, input logic [1:0] d,
                          input logic e, input bit gap, input int base, input int step,
                          input int req_at, input int abort_at);
      int sent;
      int k;
      int taps;
      bit aborted;
      taps = 24 * (int'(m) + 1);
      exp_idx = 0;
      wr_cnt = 0;
      done_cnt = 0;
      aborted = 0;
      req = 1'b1; req_mode = m; req_gain = g; req_deci = d; req_en = e;
      tick();
      req = 1'b0;
      check("en_low_after_req", int'(en_rfir), 0);
      check("busy_after_req", int'(busy), 1);
      k = 0;
      while (!c_ready && k < 20) begin
         tick();
         k++;
      end
      check("flush_cycles", k, 8);
      sent = 0;
      k = 0;
      while (sent < taps && k < 400) begin
         if (sent == abort_at) begin
            c_valid = 1'b0;
            reset = 1'b0;
            tick();
            reset = 1'b1;
            aborted = 1;
            break;
         end
         c_valid = gap ? (k % 2 == 0) : 1'b1;
         c_data = 16'(base + step * sent);
         if (sent == req_at) begin
            req = 1'b1; req_mode = ~m; req_gain = ~g; req_deci = ~d; req_en = ~e;
         end
         @(negedge clk);
         if (c_valid && c_ready) sent++;
         tick();
         req = 1'b0;
         k++;
      end
      c_valid = 1'b0;
      if (!aborted) begin
         check("beats_accepted", sent, taps);
         check("c_ready_drop", int'(c_ready), 0);
         k = 0;
         while (!done && !err && k < 6) begin
            tick();
            k++;
         end
         check("commit_seen", int'(k < 6), 1);
         repeat (2) tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 100, 24, 1, 1'b0, 2'd0, 2'd2, 2'd1, 1'b1};
      vecs[1] = '{2'd2, 2'd1, 2'd3, 1'b0, 1'b1, 500, 72, 1, 1'b0, 2'd2, 2'd1, 2'd3, 1'b0};
      vecs[2] = '{2'd3, 2'd3, 2'd3, 1'b1, 1'b0, 0,    0,  0, 1'b1, 2'd2, 2'd1, 2'd3, 1'b0};
      vecs[3] = '{2'd1, 2'd0, 2'd2, 1'b1, 1'b0, -50,  48, 1, 1'b0, 2'd1, 2'd0, 2'd2, 1'b1};

      reset = 1'b0;
      req = 1'b1;
      repeat (3) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_c_ready", int'(c_ready), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_addr", int'(addr_in), 0);
      check("rst_coeff", int'(coeff_in), 0);
      check_cfg("rst", 0, 0, 0, 0);
      req = 1'b0;
      reset = 1'b1;
      tick();
      check("post_rst_busy", int'(busy), 0);

      for (int i = 0; i < 4; i++) begin
         if (vecs[i].mode == 2'd3) begin
            wr_cnt = 0;
            done_cnt = 0;
            req = 1'b1; req_mode = vecs[i].mode; req_gain = vecs[i].gain;
            req_deci = vecs[i].deci; req_en = vecs[i].en;
            tick();
            req = 1'b0;
            check("illegal_busy", int'(busy), 0);
            repeat (3) tick();
         end else begin
            do_load(vecs[i].mode, vecs[i].gain, vecs[i].deci, vecs[i].en, vecs[i].gap,
                    vecs[i].base, 1, -1, -1);
         end
         check($sformatf("v%0d_writes", i), wr_cnt, vecs[i].exp_wr);
         check($sformatf("v%0d_done", i), done_cnt, vecs[i].exp_done);
         check($sformatf("v%0d_err", i), int'(err), int'(vecs[i].exp_err));
         check($sformatf("v%0d_busy", i), int'(busy), 0);
         check_cfg($sformatf("v%0d", i), int'(vecs[i].exp_mode), int'(vecs[i].exp_gain),
                   int'(vecs[i].exp_deci), int'(vecs[i].exp_en));
      end

      do_load(2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 7, 3, 5, -1);
      check("busyreq_writes", wr_cnt, 24);
      check("busyreq_done", done_cnt, 1);
      check_cfg("busyreq", 0, 1, 2, 1);

      do_load(2'd2, 2'd3, 2'd3, 1'b0, 1'b0, 0, 1, -1, 10);
      check("abort_busy", int'(busy), 0);
      check("abort_c_ready", int'(c_ready), 0);
      check("abort_writes", wr_cnt, 10);
      check("abort_done", done_cnt, 0);
      check_cfg("abort", 0, 0, 0, 0);
      tick();
      check("abort_queue_empty", q.size(), 0);

`ifdef RFIR_LOADER_CHECKSUM_EN
      chk = 16'd24;
      do_load(2'd0, 2'd3, 2'd2, 1'b1, 1'b0, 1, 0, -1, -1);
      check("chk_ok_done", done_cnt, 1);
      check("chk_ok_err", int'(err), 0);
      check_cfg("chk_ok", 0, 3, 2, 1);
      chk = 16'd23;
      do_load(2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1, 0, -1, -1);
      check("chk_bad_done", done_cnt, 0);
      check("chk_bad_err", int'(err), 1);
      check("chk_bad_busy", int'(busy), 0);
      check_cfg("chk_bad", 0, 3, 2, 1);
`endif

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
